// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED blink scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, pattern/step widths, and a clog2 helper
// used to size the round-robin pointer and prescaler counters.
package led_sched_pkg;

  localparam int PAT_W  = 8;
  localparam int STEP_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BLINK = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  // Minimum of 1 so a counter that only ever holds 0 still has a legal width.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    if (w == 0) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clocks.
// Latency: tick is combinational from the counter; counter wraps at TICK_DIV-1.
// Backpressure: none; never stalls and is not restarted by grants.
//
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (counter -> 0)
//   tick_o : high for the single cycle in which the counter equals TICK_DIV-1
module led_tick_gen
  import led_sched_pkg::*;
#(
  parameter int TICK_DIV = 12500000
)(
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CNT_W = clog2(TICK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Round-robin scheduler sharing two LED pins among NREQ requesters, each playing an 8-bit pattern.
// Latency: GRANT 1 cycle after REQ in IDLE; first lit bit at the first prescaler tick after GRANT.
// Backpressure: non-granted requests wait until IDLE; dropping the granted REQ aborts to the dark gap.
//
// Ports:
//   CLOCK_IN, RESET     : clock and synchronous active-high reset
//   REQ[NREQ]           : level requests, held until DONE or abort
//   PATTERN[8*NREQ]     : per-requester pattern, latched at grant
//   GRANT[NREQ]         : registered one-hot grant (0 when none / in gap)
//   BUSY, DONE          : not-IDLE flag; 1-cycle pulse on normal completion
//   OUT_HIGH, OUT_LOW   : LED A = pattern bit, LED B = its inverse, both 0 outside BLINK
// Build option: define LED_PWM_DIM_EN to gate both LEDs to a 1/4 duty cycle.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TICK_DIV  = 12500000,
  parameter int REPEATS   = 2,
  parameter int GAP_TICKS = 2
)(
  input  logic                  CLOCK_IN,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       REQ,
  input  logic [PAT_W*NREQ-1:0] PATTERN,
  output logic [NREQ-1:0]       GRANT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  OUT_HIGH,
  output logic                  OUT_LOW
);

  localparam int PTR_W  = clog2(NREQ);
  localparam int PASS_W = clog2(REPEATS);
  localparam int GAP_W  = clog2(GAP_TICKS);

  logic tick;

  led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (CLOCK_IN),
    .rst_i  (RESET),
    .tick_o (tick)
  );

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                done_c;

  // Rotating search: first active request at or after rr_ptr+1 wins.
  logic             win_vld;
  logic [PTR_W-1:0] win_idx;
  int               idx;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_vld && REQ[PTR_W'(idx)]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  logic [PAT_W*NREQ-1:0] pat_shift;
  assign pat_shift = PATTERN >> {win_idx, 3'b000};

  logic granted_req;
  logic last_step;
  assign granted_req = |(REQ & grant_q);
  assign last_step   = (step_q == STEP_W'(7)) && (pass_q == PASS_W'(REPEATS - 1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    pat_d    = pat_q;
    step_d   = step_q;
    pass_d   = pass_q;
    gap_d    = gap_q;
    rr_ptr_d = rr_ptr_q;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d          = S_GRANT;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          pat_d            = pat_shift[PAT_W-1:0];
          step_d           = '0;
          pass_d           = '0;
          rr_ptr_d         = win_idx;
        end
      end
      S_GRANT: begin
        // Abort is checked before the tick so a dropped request never starts playback.
        if (!granted_req) begin
          state_d = S_GAP;
          grant_d = '0;
          gap_d   = '0;
        end else if (tick) begin
          state_d = S_BLINK;
        end
      end
      S_BLINK: begin
        // Abort has priority over a coincident final tick: no DONE in that case.
        if (!granted_req) begin
          state_d = S_GAP;
          grant_d = '0;
          gap_d   = '0;
        end else if (tick) begin
          if (last_step) begin
            done_c  = 1'b1;
            state_d = S_GAP;
            grant_d = '0;
            gap_d   = '0;
          end else begin
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(7)) pass_d = pass_q + PASS_W'(1);
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_q == GAP_W'(GAP_TICKS - 1)) state_d = S_IDLE;
          else                                 gap_d   = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      pat_q    <= '0;
      step_q   <= '0;
      pass_q   <= '0;
      gap_q    <= '0;
      rr_ptr_q <= PTR_W'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      pat_q    <= pat_d;
      step_q   <= step_d;
      pass_q   <= pass_d;
      gap_q    <= gap_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  logic led_on;
  logic pat_bit;
  assign pat_bit = pat_q[step_q];

`ifdef LED_PWM_DIM_EN
  // LEDs may only light in the cycle where the dimming counter reads 0.
  logic [1:0] dim_q;
  always_ff @(posedge CLOCK_IN) begin
    if (RESET) dim_q <= 2'd0;
    else       dim_q <= dim_q + 2'd1;
  end
  assign led_on = (state_q == S_BLINK) && (dim_q == 2'd0);
`else
  assign led_on = (state_q == S_BLINK);
`endif

  assign GRANT    = grant_q;
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = done_c;
  assign OUT_HIGH = led_on & pat_bit;
  assign OUT_LOW  = led_on & ~pat_bit;

endmodule
